// File: rtl/key_store_pkg.sv
// Shared types and helpers for the parametrised SM4 key store.
package key_store_pkg;

  typedef enum logic {
    ST_ZERO = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Entries 32, 95 and 127 are decoys in the reference 128-entry layout.
  localparam logic [127:0] KS_DEFAULT_DECOY_MAP =
    (128'd1 << 32) | (128'd1 << 95) | (128'd1 << 127);

  // An access is refused when it is out of range or hits a decoy. A write is
  // also refused when the entry is already locked.
  function automatic logic is_rejected(input int unsigned addr,
                                       input int unsigned depth,
                                       input logic        we,
                                       input logic        lock,
                                       input logic        decoy_hit);
    return (addr >= depth) || decoy_hit || (we && lock);
  endfunction

endpackage

// File: rtl/key_store_zeroizer.sv
// Zeroize sequencer: walks every entry once after reset or on request,
// producing one clear strobe per cycle for the storage array.
module key_store_zeroizer
  import key_store_pkg::*;
#(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_zeroize,
  output logic          o_busy,
  output logic          o_clr_en,
  output logic [AW-1:0] o_clr_addr
);

  state_e        state_q;
  logic [AW-1:0] zcnt_q;
  logic          busy_q;

  // Walk state machine; a zeroize request mid-walk restarts from entry 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_ZERO;
      zcnt_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_ZERO: begin
          if (i_zeroize) begin
            zcnt_q <= '0;
          end else if (zcnt_q == AW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            zcnt_q  <= '0;
          end else begin
            zcnt_q <= zcnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_zeroize) begin
            state_q <= ST_ZERO;
            busy_q  <= 1'b1;
            zcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_ZERO;
          busy_q  <= 1'b1;
          zcnt_q  <= '0;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_clr_en   = busy_q;
  assign o_clr_addr = zcnt_q;

endmodule

// File: rtl/key_store_param.sv
// Parametrised write-once key store feeding the SM4 round-key expander.
// Optional feature: define KEY_STORE_PARITY_EN to keep one even-parity bit
// per entry and refuse reads whose stored parity no longer matches.
module key_store_param
  import key_store_pkg::*;
#(
  parameter  int unsigned      KEY_W      = 128,
  parameter  int unsigned      DEPTH      = 128,
  parameter  logic [DEPTH-1:0] DECOY_MAP  = DEPTH'(KS_DEFAULT_DECOY_MAP),
  parameter  logic [KEY_W-1:0] MASK       = '0,
  parameter  bit               WRITE_LOCK = 1'b1,
  localparam int unsigned      AW         = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  input  logic             i_req_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [KEY_W-1:0] i_wdata,
  output logic             o_req_ready,
  output logic [KEY_W-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_rerr,
  output logic             o_wack,
  output logic             o_werr,
  input  logic             i_zeroize,
  output logic             o_busy,
  output logic [AW:0]      o_lock_cnt
);

  logic          busy;
  logic          clr_en;
  logic [AW-1:0] clr_addr;

  key_store_zeroizer #(.DEPTH(DEPTH)) u_zeroizer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_zeroize  (i_zeroize),
    .o_busy     (busy),
    .o_clr_en   (clr_en),
    .o_clr_addr (clr_addr)
  );

  // Storage is never flop-reset; the zeroize walk is the only way to clear it.
  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] lock_q;
`ifdef KEY_STORE_PARITY_EN
  logic [DEPTH-1:0] par_q;
`endif

  logic             accept, in_range, decoy_hit, lock_hit, rej, parity_ok;
  logic [KEY_W-1:0] rd_word;
  logic             mem_we, mem_lock;
  logic [AW-1:0]    mem_waddr;
  logic [KEY_W-1:0] mem_wdata;
  logic             rvalid_d, rerr_d, wack_d, werr_d;
  logic             rvalid_q, rerr_q, wack_q, werr_q;
  logic [KEY_W-1:0] rdata_d, rdata_q;
  logic [AW:0]      lock_cnt_d, lock_cnt_q;

  assign o_req_ready = !busy && !i_zeroize;
  assign o_busy      = busy;

  // Request decode, storage write port selection and next response values.
  always_comb begin
    accept    = i_req_valid && o_req_ready;
    in_range  = 32'(i_addr) < DEPTH;
    decoy_hit = in_range && DECOY_MAP[i_addr];
    lock_hit  = in_range && lock_q[i_addr];
    rej       = is_rejected(32'(i_addr), DEPTH, i_req_we, lock_hit, decoy_hit);
    rd_word   = mem_q[i_addr];
`ifdef KEY_STORE_PARITY_EN
    parity_ok = (par_q[i_addr] == ^rd_word);
`else
    parity_ok = 1'b1;
`endif

    mem_we    = 1'b0;
    mem_lock  = 1'b0;
    mem_waddr = i_addr;
    mem_wdata = i_wdata;
    if (clr_en) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (accept && i_req_we && !rej) begin
      mem_we   = 1'b1;
      mem_lock = WRITE_LOCK;
    end

    rvalid_d = accept && !i_req_we && !rej && parity_ok;
    rerr_d   = accept && !i_req_we && (rej || !parity_ok);
    wack_d   = accept && i_req_we && !rej;
    werr_d   = accept && i_req_we && rej;

    rdata_d = rdata_q;
    if (i_zeroize) begin
      rdata_d = '0;
    end else if (accept && !i_req_we) begin
      rdata_d = rvalid_d ? (rd_word ^ MASK) : '0;
    end

    lock_cnt_d = lock_cnt_q;
    if (clr_en || i_zeroize) begin
      lock_cnt_d = '0;
    end else if (wack_d && WRITE_LOCK) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  // Storage, lock and parity write port (clear walk has priority).
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr]  <= mem_wdata;
      lock_q[mem_waddr] <= mem_lock;
`ifdef KEY_STORE_PARITY_EN
      par_q[mem_waddr]  <= ^mem_wdata;
`endif
    end
  end

  // One-cycle response pulses, held read data and locked-entry count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
      wack_q     <= 1'b0;
      werr_q     <= 1'b0;
      rdata_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      wack_q     <= wack_d;
      werr_q     <= werr_d;
      rdata_q    <= rdata_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign o_rvalid   = rvalid_q;
  assign o_rerr     = rerr_q;
  assign o_wack     = wack_q;
  assign o_werr     = werr_q;
  assign o_rdata    = rdata_q;
  assign o_lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_key_store_param.sv
// Scoreboard bench for key_store_param (DEPTH=100, non-zero read mask).
module tb_key_store_param;

  localparam int KW    = 128;
  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam logic [KW-1:0] TB_MASK = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [KW-1:0] wdata = '0;
  logic          zeroize = 1'b0;
  logic          req_ready, rvalid, rerr, wack, werr, busy;
  logic [KW-1:0] rdata;
  logic [AW:0]   lock_cnt;

  always #5 clk = ~clk;

  key_store_param #(.KEY_W(KW), .DEPTH(DEPTH), .MASK(TB_MASK)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_req_ready (req_ready),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_rerr      (rerr),
    .o_wack      (wack),
    .o_werr      (werr),
    .i_zeroize   (zeroize),
    .o_busy      (busy),
    .o_lock_cnt  (lock_cnt)
  );

  // kind: 0 read ok, 1 read refused, 2 write stored, 3 write refused
  typedef struct {
    int            kind;
    logic [KW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [KW-1:0] m_mem [DEPTH];
  bit            m_lock [DEPTH];
  int            m_lock_cnt;
  int            errors = 0;
  int            checks = 0;

  function automatic void check(string name, logic [KW-1:0] act, logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit is_decoy(int a);
    return (a == 32) || (a == 95) || (a == 127);
  endfunction

  function automatic void model_zeroize();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_lock[i] = 1'b0;
    end
    m_lock_cnt = 0;
  endfunction

  function automatic exp_t model_req(bit we, int a, logic [KW-1:0] d);
    exp_t e;
    e.data = '0;
    if (a >= DEPTH || is_decoy(a)) begin
      e.kind = we ? 3 : 1;
    end else if (we) begin
      if (m_lock[a]) begin
        e.kind = 3;
      end else begin
        m_mem[a]  = d;
        m_lock[a] = 1'b1;
        m_lock_cnt++;
        e.kind = 2;
      end
    end else begin
      e.kind = 0;
      e.data = m_mem[a] ^ TB_MASK;
    end
    return e;
  endfunction

  function automatic logic [KW-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one request; expectation is queued only once the DUT is ready.
  task automatic issue(bit we, int a, logic [KW-1:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    addr      = AW'(a);
    wdata     = d;
    #1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready) begin
      exp_q.push_back(model_req(we, a, d));
    end else begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (addr %0d)", a);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count busy samples starting at the current negedge; optionally re-pulse
  // zeroize at sample index pulse_at to restart the walk.
  task automatic count_busy(int pulse_at, output int n, output int bad_ready);
    n = 0;
    bad_ready = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      if (req_ready) bad_ready++;
      zeroize = (n == pulse_at);
      n++;
      @(negedge clk);
    end
    zeroize = 1'b0;
  endtask

  // Monitor: pops one expectation per response pulse.
  initial begin
    exp_t e;
    int   n;
    int   kind;
    forever begin
      @(negedge clk);
      n = int'(rvalid === 1'b1) + int'(rerr === 1'b1) + int'(wack === 1'b1) + int'(werr === 1'b1);
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL resp_onehot: got %0d pulses expected 1", n);
      end else if (n == 1) begin
        kind = (rvalid === 1'b1) ? 0 : (rerr === 1'b1) ? 1 : (wack === 1'b1) ? 2 : 3;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got kind %0d expected none", kind);
        end else begin
          e = exp_q.pop_front();
          check("resp_kind", KW'(kind), KW'(e.kind));
          if (e.kind <= 1) check("resp_rdata", rdata, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, bad;
    logic [KW-1:0] k;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", KW'(req_ready), '0);
    check("rst_busy", KW'(busy), KW'(1));
    check("rst_pulses", KW'({rvalid, rerr, wack, werr}), '0);
    check("rst_rdata", rdata, '0);
    check("rst_lock_cnt", KW'(lock_cnt), '0);
    rst = 1'b0;
    model_zeroize();
    count_busy(-1, nb, bad);
    check("init_busy_cycles", KW'(nb), KW'(DEPTH));
    check("init_ready_while_busy", KW'(bad), '0);
    check("init_ready_after", KW'(req_ready), KW'(1));

    // Fresh entry reads as zero (masked)
    issue(0, 5, '0);
    k = 128'h0123456789ABCDEF0123456789ABCDEF;
    issue(1, 5, k);
    issue(0, 5, '0);
    idle();
    check("lock_cnt_after_write", KW'(lock_cnt), KW'(m_lock_cnt));

    // Locked entry, decoy write, decoy read
    issue(1, 5, rnd_key());
    issue(1, 32, rnd_key());
    issue(0, 95, '0);
    issue(0, 5, '0);
    idle();
    check("lock_cnt_after_rejects", KW'(lock_cnt), KW'(m_lock_cnt));

    // Range boundaries
    issue(1, 110, rnd_key());
    issue(0, 110, '0);
    issue(1, DEPTH - 1, rnd_key());
    issue(0, DEPTH - 1, '0);
    issue(0, 127, '0);
    issue(1, 0, rnd_key());
    issue(0, 0, '0);
    idle();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), rnd_key());
    end
    idle();
    check("lock_cnt_random", KW'(lock_cnt), KW'(m_lock_cnt));

    // Read just before zeroize still responds; request with zeroize is refused
    issue(0, 5, '0);
    @(negedge clk);
    zeroize   = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    addr      = AW'(5);
    wdata     = rnd_key();
    #1;
    check("ready_with_zeroize", KW'(req_ready), '0);
    model_zeroize();
    @(negedge clk);
    req_valid = 1'b0;
    check("rdata_cleared_on_zeroize", rdata, '0);
    check("lock_cnt_cleared", KW'(lock_cnt), '0);
    count_busy(10, nb, bad);
    check("zeroize_restart_busy_cycles", KW'(nb), KW'(11 + DEPTH));
    check("zeroize_ready_while_busy", KW'(bad), '0);

    for (int a = 0; a < 10; a++) issue(0, a, '0);
    issue(1, 5, k);
    issue(0, 5, '0);
    idle();
    check("lock_cnt_after_rewrite", KW'(lock_cnt), KW'(m_lock_cnt));

`ifdef KEY_STORE_PARITY_EN
    begin
      exp_t e;
      issue(1, 7, rnd_key());
      idle();
      @(negedge clk);
      dut.mem_q[7][3] = ~dut.mem_q[7][3];
      req_valid = 1'b1;
      req_we    = 1'b0;
      addr      = AW'(7);
      #1;
      e.kind = 1;
      e.data = '0;
      exp_q.push_back(e);
      @(posedge clk);
      idle();
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", KW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
